// File: rtl/age_issue_queue_if.sv
// age_issue_queue_if: enqueue, wakeup, redirect, function-unit and issue signals of the age-ordered issue queue.
// Ports: master = rename/execute side driving the queue; slave = the queue itself.
//   enq_*  : iwd enqueue lanes (valid/ready, opid, class, sources, busy bits, payload)
//   wk_*   : wwd wakeup strobes with woken physical register
//   fu_ready : per-class acceptance; red_* : redirect/flush request
//   iss_*  : ewd issue ports (valid/ready, opid, payload); count : occupied entries
interface age_issue_queue_if #(
    parameter int iwd  = 2,
    parameter int ewd  = 4,
    parameter int ncls = 2,
    parameter int iqsz = 16,
    parameter int wwd  = 4,
    parameter int prw  = 7,
    parameter int pwd  = 128
);
    localparam int clw = ncls > 1 ? $clog2(ncls) : 1;
    localparam int cw  = $clog2(iqsz) + 1;
    logic [iwd-1:0]                enq_valid;
    logic [iwd-1:0]                enq_ready;
    logic [iwd-1:0][15:0]          enq_opid;
    logic [iwd-1:0][clw-1:0]       enq_cls;
    logic [iwd-1:0][1:0][prw-1:0]  enq_prsa;
    logic [iwd-1:0][1:0]           enq_busy;
    logic [iwd-1:0][pwd-1:0]       enq_pay;
    logic [wwd-1:0]                wk_valid;
    logic [wwd-1:0][prw-1:0]       wk_prda;
    logic [ncls-1:0]               fu_ready;
    logic                          red_valid;
    logic [15:0]                   red_opid;
    logic [15:0]                   red_topid;
    logic [ewd-1:0]                iss_valid;
    logic [ewd-1:0]                iss_ready;
    logic [ewd-1:0][15:0]          iss_opid;
    logic [ewd-1:0][pwd-1:0]       iss_pay;
    logic [cw-1:0]                 count;
    modport master (
        output enq_valid, enq_opid, enq_cls, enq_prsa, enq_busy, enq_pay,
        output wk_valid, wk_prda, fu_ready, red_valid, red_opid, red_topid, iss_ready,
        input  enq_ready, iss_valid, iss_opid, iss_pay, count
    );
    modport slave (
        input  enq_valid, enq_opid, enq_cls, enq_prsa, enq_busy, enq_pay,
        input  wk_valid, wk_prda, fu_ready, red_valid, red_opid, red_topid, iss_ready,
        output enq_ready, iss_valid, iss_opid, iss_pay, count
    );
endinterface

// File: rtl/age_issue_queue.sv
// age_issue_queue: out-of-order issue queue with age-matrix oldest-first selection per function-unit class.
// Ports: clk_i clock; rst_ni asynchronous active-low reset; q slave view of age_issue_queue_if
//   (enqueue lanes, wakeups, fu_ready, redirect, issue ports, count).
module age_issue_queue #(
    parameter int iwd  = 2,
    parameter int ewd  = 4,
    parameter int ncls = 2,
    parameter int iqsz = 16,
    parameter int wwd  = 4,
    parameter int opsz = 64,
    parameter int prw  = 7,
    parameter int pwd  = 128
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    age_issue_queue_if.slave q
);
    localparam int clw = ncls > 1 ? $clog2(ncls) : 1;
    localparam int cw  = $clog2(iqsz) + 1;
    localparam int sw  = iqsz > 1 ? $clog2(iqsz) : 1;
    localparam int lw  = iwd > 1 ? $clog2(iwd) : 1;
    localparam int ow  = $clog2(opsz);

    logic [iqsz-1:0]                occ_q, occ_d;
    logic [iqsz-1:0][1:0]           busy_q, busy_d;
    logic [iqsz-1:0][iqsz-1:0]      age_q, age_d;
    logic [cw-1:0]                  count_q, count_d;
    logic [iqsz-1:0][15:0]          opid_q;
    logic [iqsz-1:0][clw-1:0]       cls_q;
    logic [iqsz-1:0][1:0][prw-1:0]  prsa_q;
    logic [iqsz-1:0][pwd-1:0]       pay_q;

    logic [iqsz-1:0][1:0]           bfwd;
    logic [iqsz-1:0]                flush, rdy, fire, en;
    logic [iqsz-1:0][cw-1:0]        rank;
    logic [iqsz-1:0][lw-1:0]        ln;
    logic [ewd-1:0]                 pv, iss_v;
    logic [ewd-1:0][sw-1:0]         sel;
    logic [ewd-1:0][15:0]           iss_op;
    logic [ewd-1:0][pwd-1:0]        iss_pl;
    logic [iwd-1:0]                 erdy, acc;
    logic [cw-1:0]                  free;

    function automatic logic wk_hit(input logic [prw-1:0] r, input logic [wwd-1:0] wv,
                                    input logic [wwd-1:0][prw-1:0] wp);
        logic h;
        h = 1'b0;
        for (int w = 0; w < wwd; w++) h = h | (wv[w] & (wp[w] == r));
        return h;
    endfunction

    // Readiness uses wakeup-forwarded busy bits; flush compares opids relative to the ring base.
    always_comb begin : ready_logic
        logic [ow-1:0] dr, ds;
        dr = ow'(q.red_opid - q.red_topid);
        for (int s = 0; s < iqsz; s++) begin
            for (int k = 0; k < 2; k++)
                bfwd[s][k] = busy_q[s][k] & ~wk_hit(prsa_q[s][k], q.wk_valid, q.wk_prda);
            ds = ow'(opid_q[s] - q.red_topid);
            flush[s] = q.red_valid & occ_q[s] & (ds > dr);
            rdy[s] = occ_q[s] & ~bfwd[s][0] & ~bfwd[s][1] & q.fu_ready[cls_q[s]] & ~flush[s];
        end
    end

    always_comb begin
        for (int s = 0; s < iqsz; s++) begin
            rank[s] = '0;
            for (int j = 0; j < iqsz; j++)
                rank[s] = rank[s] + cw'(rdy[j] & (cls_q[j] == cls_q[s]) & age_q[j][s]);
        end
    end

    // Port p is the (p / ncls)-th port of class p mod ncls and takes the entry of that rank.
    always_comb begin
        for (int p = 0; p < ewd; p++) begin
            pv[p] = 1'b0;
            sel[p] = '0;
            for (int s = 0; s < iqsz; s++)
                if (rdy[s] && cls_q[s] == clw'(p % ncls) && rank[s] == cw'(p / ncls)) begin
                    pv[p] = 1'b1;
                    sel[p] = sw'(s);
                end
            iss_v[p] = pv[p] & ~q.red_valid;
            iss_op[p] = pv[p] ? opid_q[sel[p]] : '0;
            iss_pl[p] = pv[p] ? pay_q[sel[p]] : '0;
        end
    end

    // Accepted lanes fill the lowest free slots in lane order; readiness depends only on count.
    always_comb begin : alloc
        int n;
        fire = '0;
        for (int p = 0; p < ewd; p++)
            for (int s = 0; s < iqsz; s++)
                if (iss_v[p] && q.iss_ready[p] && sel[p] == sw'(s)) fire[s] = 1'b1;
        free = cw'(iqsz) - count_q;
        for (int i = 0; i < iwd; i++) begin
            erdy[i] = (free > cw'(i)) & ~q.red_valid;
            acc[i] = q.enq_valid[i] & erdy[i];
        end
        n = 0;
        for (int s = 0; s < iqsz; s++) begin
            en[s] = 1'b0;
            ln[s] = '0;
            if (!occ_q[s]) begin
                if (n < iwd) begin
                    en[s] = acc[n];
                    ln[s] = lw'(n);
                end
                n++;
            end
        end
        occ_d = (occ_q & ~flush & ~fire) | en;
        age_d = age_q;
        for (int s = 0; s < iqsz; s++) begin
            for (int k = 0; k < 2; k++)
                busy_d[s][k] = en[s] ? q.enq_busy[ln[s]][k] & ~wk_hit(q.enq_prsa[ln[s]][k], q.wk_valid, q.wk_prda)
                                     : bfwd[s][k];
            // A new entry is younger than all residents and than lower lanes of the same cycle.
            for (int j = 0; j < iqsz; j++)
                age_d[s][j] = en[s] ? en[j] & (ln[s] < ln[j]) : en[j] ? occ_q[s] : age_q[s][j];
        end
        count_d = cw'($countones(occ_d));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= '0;
            busy_q  <= '0;
            age_q   <= '0;
            count_q <= '0;
        end else begin
            occ_q   <= occ_d;
            busy_q  <= busy_d;
            age_q   <= age_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < iqsz; s++)
            if (en[s]) begin
                opid_q[s] <= q.enq_opid[ln[s]];
                cls_q[s]  <= q.enq_cls[ln[s]];
                prsa_q[s] <= q.enq_prsa[ln[s]];
                pay_q[s]  <= q.enq_pay[ln[s]];
            end
    end

    assign q.enq_ready = erdy;
    assign q.iss_valid = iss_v;
    assign q.iss_opid  = iss_op;
    assign q.iss_pay   = iss_pl;
    assign q.count     = count_q;
endmodule

// File: tb/tb_age_issue_queue.sv
// tb_age_issue_queue: directed table-driven bench for age_issue_queue plus hand-written multi-cycle sequences.
module tb_age_issue_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    age_issue_queue_if bus ();
    age_issue_queue dut (.clk_i(clk), .rst_ni(rst_n), .q(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [1:0]  ev;
        logic [15:0] o0, o1;
        logic        c0, c1;
        logic [1:0]  b0;
        logic        wk;
        logic [1:0]  fr;
        logic [3:0]  xiv;
        logic [15:0] x0, x1, x2, x3;
        logic [4:0]  xcnt;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(string nm, logic [1:0] ev, int o0, int o1, logic c0, logic c1,
                                logic [1:0] b0, logic wk, logic [1:0] fr, logic [3:0] xiv,
                                int x0, int x1, int x2, int x3, int xcnt);
        vec_t v;
        v.nm = nm; v.ev = ev; v.o0 = 16'(o0); v.o1 = 16'(o1); v.c0 = c0; v.c1 = c1;
        v.b0 = b0; v.wk = wk; v.fr = fr; v.xiv = xiv;
        v.x0 = 16'(x0); v.x1 = 16'(x1); v.x2 = 16'(x2); v.x3 = 16'(x3); v.xcnt = 5'(xcnt);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] ev, input logic [15:0] o0, input logic [15:0] o1,
                       input logic c0, input logic c1, input logic [1:0] b0, input logic wk,
                       input logic [1:0] fr, input logic [3:0] ir, input logic rv,
                       input logic [15:0] ro, input logic [15:0] rt);
        bus.enq_valid = ev;
        bus.enq_opid[0] = o0;
        bus.enq_opid[1] = o1;
        bus.enq_cls[0] = c0;
        bus.enq_cls[1] = c1;
        bus.enq_busy[0] = b0;
        bus.enq_busy[1] = 2'b00;
        bus.enq_prsa[0][0] = 7'd42;
        bus.enq_prsa[0][1] = 7'd1;
        bus.enq_prsa[1][0] = 7'd1;
        bus.enq_prsa[1][1] = 7'd1;
        bus.enq_pay[0] = {8{o0}};
        bus.enq_pay[1] = {8{o1}};
        bus.wk_valid = {3'b000, wk};
        bus.wk_prda = '0;
        bus.wk_prda[0] = 7'd42;
        bus.fu_ready = fr;
        bus.iss_ready = ir;
        bus.red_valid = rv;
        bus.red_opid = ro;
        bus.red_topid = rt;
    endtask

    task automatic idle(input logic [1:0] fr, input logic [3:0] ir);
        drv(2'b00, 16'd0, 16'd0, 1'b0, 1'b0, 2'b00, 1'b0, fr, ir, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic apply(input vec_t v);
        logic [3:0][15:0] xo;
        drv(v.ev, v.o0, v.o1, v.c0, v.c1, v.b0, v.wk, v.fr, 4'b1111, 1'b0, 16'd0, 16'd0);
        #2;
        xo = {v.x3, v.x2, v.x1, v.x0};
        chk($sformatf("%s iss_valid", v.nm), 128'(bus.iss_valid), 128'(v.xiv));
        chk($sformatf("%s count", v.nm), 128'(bus.count), 128'(v.xcnt));
        chk($sformatf("%s enq_ready", v.nm), 128'(bus.enq_ready), 128'(2'b11));
        for (int p = 0; p < 4; p++)
            if (v.xiv[p]) begin
                chk($sformatf("%s opid[%0d]", v.nm, p), 128'(bus.iss_opid[p]), 128'(xo[p]));
                chk($sformatf("%s pay[%0d]", v.nm, p), bus.iss_pay[p], {8{xo[p]}});
            end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk("enq56",      2'b11,  5,  6, 0, 0, 2'b00, 0, 2'b00, 4'b0000,  0,  0, 0,  0, 0);
        tbl[1]  = mk("enq7",       2'b01,  7,  0, 0, 0, 2'b00, 0, 2'b00, 4'b0000,  0,  0, 0,  0, 2);
        tbl[2]  = mk("old56",      2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0101,  5,  0, 6,  0, 3);
        tbl[3]  = mk("old7",       2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0001,  7,  0, 0,  0, 1);
        tbl[4]  = mk("empty",      2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 0);
        tbl[5]  = mk("byp_enq",    2'b01,  9,  0, 0, 0, 2'b01, 1, 2'b11, 4'b0000,  0,  0, 0,  0, 0);
        tbl[6]  = mk("byp_iss",    2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0001,  9,  0, 0,  0, 1);
        tbl[7]  = mk("nobyp_enq",  2'b01,  9,  0, 0, 0, 2'b01, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 0);
        tbl[8]  = mk("nobyp_hold", 2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 1);
        tbl[9]  = mk("nobyp_hld2", 2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 1);
        tbl[10] = mk("late_wake",  2'b00,  0,  0, 0, 0, 2'b00, 1, 2'b11, 4'b0001,  9,  0, 0,  0, 1);
        tbl[11] = mk("drained",    2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 0);
        tbl[12] = mk("c1_enq",     2'b11, 20, 21, 1, 1, 2'b00, 0, 2'b01, 4'b0000,  0,  0, 0,  0, 0);
        tbl[13] = mk("c1_enq2",    2'b01, 22,  0, 1, 0, 2'b00, 0, 2'b01, 4'b0000,  0,  0, 0,  0, 2);
        tbl[14] = mk("c1_gated",   2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b01, 4'b0000,  0,  0, 0,  0, 3);
        tbl[15] = mk("c1_open",    2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b1010,  0, 20, 0, 21, 3);
        tbl[16] = mk("c1_last",    2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0010,  0, 22, 0,  0, 1);
        tbl[17] = mk("c1_empty",   2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 0);
        tbl[18] = mk("mix_enq",    2'b11, 30, 31, 0, 1, 2'b00, 0, 2'b00, 4'b0000,  0,  0, 0,  0, 0);
        tbl[19] = mk("mix_iss",    2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0011, 30, 31, 0,  0, 2);
        tbl[20] = mk("mix_empty",  2'b00,  0,  0, 0, 0, 2'b00, 0, 2'b11, 4'b0000,  0,  0, 0,  0, 0);

        idle(2'b11, 4'b1111);
        #2;
        chk("reset count", 128'(bus.count), 128'(0));
        chk("reset iss_valid", 128'(bus.iss_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("post-reset enq_ready", 128'(bus.enq_ready), 128'(2'b11));
        @(negedge clk);

        for (int i = 0; i < 21; i++) apply(tbl[i]);

        // Stall: port 1 holds opid 40 while its consumer is not ready.
        drv(2'b01, 16'd40, 16'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b11, 4'b1111, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            idle(2'b11, 4'b1101);
            #2;
            chk($sformatf("stall%0d iss_valid[1]", c), 128'(bus.iss_valid[1]), 128'(1));
            chk($sformatf("stall%0d opid[1]", c), 128'(bus.iss_opid[1]), 128'(40));
            chk($sformatf("stall%0d count", c), 128'(bus.count), 128'(1));
            @(negedge clk);
        end
        idle(2'b11, 4'b1111);
        #2;
        chk("stall release iss_valid[1]", 128'(bus.iss_valid[1]), 128'(1));
        @(negedge clk);
        #2;
        chk("stall release count", 128'(bus.count), 128'(0));
        @(negedge clk);

        // Fill with a wrapping opid run 60..63, 0..11.
        for (int c = 0; c < 8; c++) begin
            drv(2'b11, 16'((60 + 2 * c) % 64), 16'((61 + 2 * c) % 64), 1'b0, 1'b0, 2'b00, 1'b0,
                2'b00, 4'b1111, 1'b0, 16'd0, 16'd60);
            @(negedge clk);
        end
        idle(2'b00, 4'b1111);
        #2;
        chk("full count", 128'(bus.count), 128'(16));
        chk("full enq_ready", 128'(bus.enq_ready), 128'(0));
        @(negedge clk);
        drv(2'b11, 16'd50, 16'd51, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b1111, 1'b1, 16'd3, 16'd60);
        #2;
        chk("flush iss_valid", 128'(bus.iss_valid), 128'(0));
        chk("flush enq_ready", 128'(bus.enq_ready), 128'(0));
        @(negedge clk);
        idle(2'b00, 4'b1111);
        #2;
        chk("after flush count", 128'(bus.count), 128'(8));
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            drv(2'b11, 16'(4 + 2 * c), 16'(5 + 2 * c), 1'b0, 1'b0, 2'b00, 1'b0,
                2'b00, 4'b1111, 1'b0, 16'd0, 16'd60);
            @(negedge clk);
        end
        // Full queue issuing two entries still refuses enqueue this cycle.
        drv(2'b11, 16'd50, 16'd51, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 4'b1111, 1'b0, 16'd0, 16'd60);
        #2;
        chk("full+issue enq_ready", 128'(bus.enq_ready), 128'(0));
        chk("full+issue iss_valid", 128'(bus.iss_valid), 128'(4'b0101));
        chk("full+issue opid[0]", 128'(bus.iss_opid[0]), 128'(60));
        chk("full+issue opid[2]", 128'(bus.iss_opid[2]), 128'(61));
        @(negedge clk);
        idle(2'b00, 4'b1111);
        #2;
        chk("full+issue count", 128'(bus.count), 128'(14));

        // Asynchronous reset in mid-cycle with five queued entries.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        drv(2'b11, 16'd70, 16'd71, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1111, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        drv(2'b11, 16'd72, 16'd73, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1111, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        drv(2'b01, 16'd74, 16'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1111, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        idle(2'b11, 4'b0000);
        #2;
        chk("pre-areset count", 128'(bus.count), 128'(5));
        chk("pre-areset iss_valid", 128'(bus.iss_valid), 128'(4'b0101));
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset count", 128'(bus.count), 128'(0));
        chk("areset iss_valid", 128'(bus.iss_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("after areset count", 128'(bus.count), 128'(0));
        chk("after areset enq_ready", 128'(bus.enq_ready), 128'(2'b11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
